// File: rtl/board_judge_if.sv
// Handshake/result bundle between the board judge and its controller.
// master: game controller side (drives clr, board, start and placement flags).
// slave : board_judge side (drives busy/done and the scan results).
interface board_judge_if #(
  parameter int unsigned BOARD_N = 5,
  parameter int unsigned LINE_W  = 4
);
  logic                           clr;
  logic [2*BOARD_N*BOARD_N-1:0]   board_in;
  logic                           scan_start;
  logic                           player_done;
  logic                           player2Done;
  logic                           busy;
  logic                           done;
  logic [1:0]                     winner;
  logic [LINE_W-1:0]              win_line;
  logic                           draw;
  logic                           game_over;
  logic                           bad_cell;

  modport master (
    output clr, board_in, scan_start, player_done, player2Done,
    input  busy, done, winner, win_line, draw, game_over, bad_cell
  );

  modport slave (
    input  clr, board_in, scan_start, player_done, player2Done,
    output busy, done, winner, win_line, draw, game_over, bad_cell
  );
endinterface

// File: rtl/board_judge.sv
// board_judge: snapshots a packed BOARD_N x BOARD_N board (2 bits/cell:
// 00 empty, 01 player 1, 10 player 2, 11 invalid) and scans one line per
// cycle (rows, columns, main diagonal, anti-diagonal) for a winner or draw.
// Ports: clk, rst (async active-high), bus (board_judge_if.slave):
//   clr, board_in, scan_start, player_done, player2Done in;
//   busy, done, winner, win_line, draw, game_over, bad_cell out (registered).
// Optional feature macro BOARD_JUDGE_AUTO_SCAN_EN: a change on either
// placement flag also requests a scan, with one pending request held while busy.
module board_judge #(
  parameter int unsigned BOARD_N = 5,
  parameter int unsigned LINE_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  board_judge_if.slave  bus
);

  localparam int unsigned CELLS = BOARD_N * BOARD_N;
  localparam int unsigned BW    = 2 * CELLS;
  localparam int unsigned L     = 2 * BOARD_N + 2;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t            state;
  logic [BW-1:0]     snap;
  logic [LINE_W-1:0] line;

  logic [L-1:0] all_p1_c;
  logic [L-1:0] all_p2_c;
  logic         snap_has_empty_c;
  logic         in_has_bad_c;
  logic         start_c;
  logic [1:0]   cell_c;

  // Flat cell index of the k-th cell on line l.
  function automatic int unsigned cell_idx(input int unsigned l, input int unsigned k);
    if (l < BOARD_N)              return l * BOARD_N + k;
    else if (l < 2 * BOARD_N)     return k * BOARD_N + (l - BOARD_N);
    else if (l == 2 * BOARD_N)    return k * BOARD_N + k;
    else                          return k * BOARD_N + (BOARD_N - 1 - k);
  endfunction

  // Per-line ownership flags plus board-wide empty/invalid detection.
  always_comb begin
    all_p1_c         = '1;
    all_p2_c         = '1;
    snap_has_empty_c = 1'b0;
    in_has_bad_c     = 1'b0;
    cell_c           = 2'b00;
    for (int unsigned l = 0; l < L; l++) begin
      for (int unsigned k = 0; k < BOARD_N; k++) begin
        cell_c = snap[2*cell_idx(l, k) +: 2];
        if (cell_c != 2'b01) all_p1_c[l] = 1'b0;
        if (cell_c != 2'b10) all_p2_c[l] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (snap[2*i +: 2] == 2'b00)         snap_has_empty_c = 1'b1;
      if (bus.board_in[2*i +: 2] == 2'b11) in_has_bad_c     = 1'b1;
    end
  end

`ifdef BOARD_JUDGE_AUTO_SCAN_EN
  logic pd_q;
  logic p2_q;
  logic pending_q;
  logic auto_c;

  // A flag edge from the placement block is a handoff; treat it as a start.
  assign auto_c  = (bus.player_done != pd_q) | (bus.player2Done != p2_q);
  assign start_c = bus.scan_start | auto_c | pending_q;

  // Flag history and the single pending request taken while a scan runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_q      <= 1'b0;
      p2_q      <= 1'b1;
      pending_q <= 1'b0;
    end else if (bus.clr) begin
      pd_q      <= 1'b0;
      p2_q      <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      pd_q <= bus.player_done;
      p2_q <= bus.player2Done;
      if (state == IDLE)  pending_q <= 1'b0;
      else if (auto_c)    pending_q <= 1'b1;
    end
  end
`else
  logic unused_flags_c;

  assign start_c        = bus.scan_start;
  assign unused_flags_c = bus.player_done ^ bus.player2Done;
`endif

  // Scan FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      snap          <= '0;
      line          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.winner    <= 2'b00;
      bus.win_line  <= '0;
      bus.draw      <= 1'b0;
      bus.game_over <= 1'b0;
      bus.bad_cell  <= 1'b0;
    end else if (bus.clr) begin
      state         <= IDLE;
      snap          <= '0;
      line          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.winner    <= 2'b00;
      bus.win_line  <= '0;
      bus.draw      <= 1'b0;
      bus.game_over <= 1'b0;
      bus.bad_cell  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c && !bus.game_over) begin
            snap         <= bus.board_in;
            line         <= '0;
            bus.winner   <= 2'b00;
            bus.win_line <= '0;
            bus.draw     <= 1'b0;
            bus.bad_cell <= in_has_bad_c;
            bus.busy     <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (all_p1_c[line] || all_p2_c[line]) begin
            bus.winner    <= all_p1_c[line] ? 2'b01 : 2'b10;
            bus.win_line  <= line;
            bus.game_over <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= REPORT;
          end else if (line == LINE_W'(L - 1)) begin
            bus.draw      <= !snap_has_empty_c;
            bus.game_over <= bus.game_over | !snap_has_empty_c;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= REPORT;
          end else begin
            line <= line + LINE_W'(1);
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_judge.sv
// Self-checking bench for board_judge: a reference model predicts each scan
// result (winner, line, draw, bad cell, latency) into a scoreboard queue that
// is drained when the DUT pulses done.
module tb_board_judge;

  localparam int N      = 5;
  localparam int LINE_W = 4;
  localparam int BW     = 2 * N * N;
  localparam int L      = 2 * N + 2;

  typedef struct {
    logic [1:0]        winner;
    logic [LINE_W-1:0] line;
    logic              draw;
    logic              bad;
    int                lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic go_exp;
  exp_t sb[$];

  board_judge_if #(.BOARD_N(N), .LINE_W(LINE_W)) bif ();

  board_judge #(.BOARD_N(N), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [BW-1:0] set_cell(input logic [BW-1:0] b, input int r,
                                             input int c, input logic [1:0] v);
    b[2*(r*N+c) +: 2] = v;
    return b;
  endfunction

  // Reference model: first fully owned line in index order, else draw check.
  function automatic exp_t model(input logic [BW-1:0] b);
    exp_t e;
    int r, c, n1, n2;
    logic [1:0] v;
    logic empty;
    e.winner = 2'b00; e.line = '0; e.draw = 1'b0; e.bad = 1'b0; e.lat = L;
    for (int l = 0; l < L; l++) begin
      n1 = 0; n2 = 0;
      for (int k = 0; k < N; k++) begin
        if (l < N)           begin r = l; c = k;         end
        else if (l < 2*N)    begin r = k; c = l - N;     end
        else if (l == 2*N)   begin r = k; c = k;         end
        else                 begin r = k; c = N - 1 - k; end
        v = b[2*(r*N+c) +: 2];
        if (v == 2'b01) n1++;
        if (v == 2'b10) n2++;
      end
      if (e.winner == 2'b00 && (n1 == N || n2 == N)) begin
        e.winner = (n1 == N) ? 2'b01 : 2'b10;
        e.line   = LINE_W'(l);
        e.lat    = l + 1;
      end
    end
    empty = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      if (b[2*i +: 2] == 2'b00) empty = 1'b1;
      if (b[2*i +: 2] == 2'b11) e.bad = 1'b1;
    end
    e.draw = (e.winner == 2'b00) && !empty;
    return e;
  endfunction

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    bif.clr = 1'b1;
    cyc1();
    bif.clr = 1'b0;
    go_exp  = 1'b0;
  endtask

  // Drives a start pulse; returns in the sample slot right after the start edge.
  task automatic start_scan(input logic [BW-1:0] b);
    bif.board_in = b;
    sb.push_back(model(b));
    bif.scan_start = 1'b1;
    cyc1();
    bif.scan_start = 1'b0;
  endtask

  // Waits for done, pops the scoreboard and compares; then checks the pulse ends.
  task automatic wait_result(input int cyc0, input int busy0, input string name);
    exp_t e;
    int   cyc, busy_n;
    bit   seen;
    cyc = cyc0; busy_n = busy0; seen = 0;
    while (!seen && cyc < 60) begin
      if (bif.busy) busy_n++;
      cyc1();
      cyc++;
      if (bif.done) seen = 1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, wanted latency %0d", name, cyc, e.lat);
      return;
    end
    checks++;
    if (cyc !== e.lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, e.lat); end
    checks++;
    if (busy_n !== e.lat) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n, e.lat); end
    checks++;
    if (bif.winner !== e.winner) begin errors++; $display("FAIL %s_winner: got %b want %b", name, bif.winner, e.winner); end
    checks++;
    if (bif.win_line !== e.line) begin errors++; $display("FAIL %s_win_line: got %0d want %0d", name, bif.win_line, e.line); end
    checks++;
    if (bif.draw !== e.draw) begin errors++; $display("FAIL %s_draw: got %b want %b", name, bif.draw, e.draw); end
    checks++;
    if (bif.bad_cell !== e.bad) begin errors++; $display("FAIL %s_bad_cell: got %b want %b", name, bif.bad_cell, e.bad); end
    if (e.winner != 2'b00 || e.draw) go_exp = 1'b1;
    cyc1();
    checks++;
    if (bif.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", name, bif.done); end
    checks++;
    if (bif.game_over !== go_exp) begin errors++; $display("FAIL %s_game_over: got %b want %b", name, bif.game_over, go_exp); end
    checks++;
    if (bif.winner !== e.winner) begin errors++; $display("FAIL %s_winner_hold: got %b want %b", name, bif.winner, e.winner); end
  endtask

  task automatic check_all_zero(input string name);
    logic [10:0] o;
    o = {bif.busy, bif.done, bif.winner, bif.win_line, bif.draw, bif.game_over, bif.bad_cell};
    checks++;
    if (o !== 11'd0) begin errors++; $display("FAIL %s_outputs_zero: got %b want 0", name, o); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc1();
    check_all_zero("reset");
    rst = 1'b0;
    cyc1();
    check_all_zero("after_reset");
  endtask

  task automatic test_empty();
    do_clr();
    start_scan('0);
    wait_result(0, 0, "empty");
  endtask

  task automatic test_row_win();
    logic [BW-1:0] b;
    b = '0;
    for (int c = 0; c < N; c++) b = set_cell(b, 0, c, 2'b01);
    do_clr();
    start_scan(b);
    wait_result(0, 0, "row0");
    // Game is over: further starts must be dropped.
    bif.scan_start = 1'b1;
    cyc1();
    bif.scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start: busy=%b done=%b want 0/0", bif.busy, bif.done);
      end
      cyc1();
    end
  endtask

  task automatic test_anti_diag();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++) b = set_cell(b, r, N - 1 - r, 2'b10);
    do_clr();
    start_scan(b);
    wait_result(0, 0, "anti_diag");
    checks++;
    if (bif.win_line !== 4'd11) begin errors++; $display("FAIL anti_diag_line11: got %0d want 11", bif.win_line); end
  endtask

  task automatic test_draw();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b = set_cell(b, r, c, ((r + c) % 2 == 1) ? 2'b10 : 2'b01);
    b = set_cell(b, 0, 0, 2'b10);
    b = set_cell(b, 1, 3, 2'b10);
    do_clr();
    start_scan(b);
    wait_result(0, 0, "draw");
    checks++;
    if (bif.draw !== 1'b1) begin errors++; $display("FAIL draw_flag: got %b want 1", bif.draw); end
    b = set_cell(b, 2, 2, 2'b11);
    do_clr();
    start_scan(b);
    wait_result(0, 0, "draw_bad");
    checks++;
    if ({bif.bad_cell, bif.draw} !== 2'b11) begin
      errors++; $display("FAIL draw_bad_flags: got %b want 11", {bif.bad_cell, bif.draw});
    end
  endtask

  // Board changes and extra starts during a scan must not disturb it.
  task automatic test_snapshot();
    logic [BW-1:0] b;
    int busy_n;
    b = '0;
    for (int c = 0; c < N; c++) b = set_cell(b, 0, c, 2'b01);
    do_clr();
    start_scan('0);
    busy_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bif.busy) busy_n++;
      cyc1();
    end
    bif.board_in   = b;
    bif.scan_start = 1'b1;
    if (bif.busy) busy_n++;
    cyc1();
    bif.scan_start = 1'b0;
    wait_result(4, busy_n, "snapshot");
  endtask

  task automatic test_clr_abort();
    bit seen;
    do_clr();
    start_scan('0);
    repeat (3) cyc1();
    bif.clr = 1'b1;
    cyc1();
    bif.clr = 1'b0;
    go_exp  = 1'b0;
    void'(sb.pop_front());
    check_all_zero("clr_abort");
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bif.done) seen = 1;
      cyc1();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL clr_no_done: got done pulse want none"); end
  endtask

  task automatic test_random();
    logic [BW-1:0] b;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N*N; i++) b[2*i +: 2] = 2'($urandom_range(0, 2));
      do_clr();
      start_scan(b);
      wait_result(0, 0, "random");
    end
  endtask

  task automatic test_async_reset();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++) b = set_cell(b, r, N - 1 - r, 2'b10);
    b = set_cell(b, 0, 0, 2'b11);
    do_clr();
    start_scan(b);
    cyc1();
    checks++;
    if ({bif.busy, bif.bad_cell} !== 2'b11) begin
      errors++; $display("FAIL midscan_flags: busy,bad got %b want 11", {bif.busy, bif.bad_cell});
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    void'(sb.pop_front());
    go_exp = 1'b0;
    cyc1();
    rst = 1'b0;
    cyc1();
    check_all_zero("post_rst");
  endtask

`ifdef BOARD_JUDGE_AUTO_SCAN_EN
  task automatic test_auto_scan();
    int busy_n;
    do_clr();
    start_scan('0);
    busy_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bif.busy) busy_n++;
      cyc1();
    end
    bif.player_done = 1'b1;
    wait_result(3, busy_n, "auto_first");
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL auto_idle_gap: busy got %b want 0", bif.busy); end
    sb.push_back(model('0));
    cyc1();
    checks++;
    if (bif.busy !== 1'b1) begin errors++; $display("FAIL auto_restart: busy got %b want 1", bif.busy); end
    wait_result(0, 0, "auto_second");
    // Flag change in IDLE starts a scan directly.
    bif.player2Done = 1'b0;
    sb.push_back(model('0));
    cyc1();
    wait_result(0, 0, "auto_idle_flag");
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    go_exp          = 1'b0;
    rst             = 1'b1;
    bif.clr         = 1'b0;
    bif.board_in    = '0;
    bif.scan_start  = 1'b0;
    bif.player_done = 1'b0;
    bif.player2Done = 1'b1;
    test_reset();
    test_empty();
    test_row_win();
    test_anti_diag();
    test_draw();
    test_snapshot();
    test_clr_abort();
    test_random();
    test_async_reset();
`ifdef BOARD_JUDGE_AUTO_SCAN_EN
    test_auto_scan();
`endif
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_judge.md
Name: board_judge

Overview:
- Reader side of the board register file. Snapshots the packed 5x5 board (2 bits per cell: 00 empty, 01 player 1, 10 player 2, 11 invalid) and scans it one line per cycle.
- Reports winner, winning line index and draw to the game controller and display logic.
- Sits downstream of the piece-placement block; triggered after each placement.

Parameters:
- BOARD_N, 5, board side length; supported 3..5; line count L = 2*BOARD_N+2.
- LINE_W, 4, width of the win_line output; must satisfy 2^LINE_W >= L.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear/new game; aborts any scan
- board_in  in  2*BOARD_N*BOARD_N  packed board; cell i=r*BOARD_N+c (0-based) at bits [2i+1:2i]
- scan_start  in  1  single-cycle scan request
- player_done  in  1  placement flag, player 1 (used only with AUTO_SCAN_EN)
- player2Done  in  1  placement flag, player 2 (used only with AUTO_SCAN_EN)
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when the result is valid
- winner  out  2  00 none, 01 player 1, 10 player 2
- win_line  out  LINE_W  winning line index; valid when winner!=00
- draw  out  1  no winner and no empty cell
- game_over  out  1  sticky: set when winner!=00 or draw
- bad_cell  out  1  snapshot contained at least one 11 cell

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; busy, done, draw, game_over and bad_cell = 0; winner = 00; win_line = 0; snapshot and line counter = 0.
- clr=1 (synchronous, priority over everything but rst): same values as reset; any scan in progress is abandoned without a done pulse.
- Line indexing:
  - 0..N-1: rows.
  - N..2N-1: columns.
  - 2N: main diagonal (r==c).
  - 2N+1: anti-diagonal (r+c==N-1).
- FSM has three states: IDLE, SCAN, REPORT.
- IDLE:
  - A start is scan_start=1 and game_over=0.
  - On a start edge E0: register board_in into the snapshot, line := 0, clear winner/win_line/draw, compute bad_cell from the snapshot input, busy := 1, go to SCAN.
  - Start while game_over=1 is ignored.
- SCAN, at each edge, evaluate snapshot line `line`:
  - All cells 01: winner := 01, win_line := line, go to REPORT.
  - All cells 10: winner := 10, win_line := line, go to REPORT.
  - Else if line == L-1: draw := (no 00 cell in snapshot), go to REPORT.
  - Else line := line+1.
  - Lines are scanned in ascending order; the first winning line is reported and later lines are not examined.
- REPORT: done=1 and busy=0 for exactly one cycle. game_over |= (winner!=00 | draw). Go to IDLE.
- Latency: a win on line i gives done high in the cycle after edge E0+(i+1). No win gives done after edge E0+L (12 cycles for N=5).
- scan_start while busy: ignored (no queueing).
- Board changes during a scan: no effect; only the snapshot is used.
- A 11 cell never counts toward a win and never counts as empty.
- winner, win_line and draw hold their values after done until the next accepted start, clr, or rst.

Optional Feature:
- Macro: BOARD_JUDGE_AUTO_SCAN_EN.
- Defined:
  - player_done and player2Done are registered each cycle.
  - Any change of either flag versus its registered copy (placement handoff) creates an internal start, ORed with scan_start.
  - If the internal start arrives while busy, one pending start is held and issued in the IDLE cycle after REPORT.
  - clr and rst also clear the pending start and the registered flags (reset to player_done=0, player2Done=1).
- Undefined: player_done and player2Done are ignored; scans start only on scan_start.

Test Plan:
- Empty board, scan_start pulse -> busy for 12 cycles; done pulse 12 cycles after the start edge; winner=00, draw=0, game_over=0.
- Cells 0..4 = 01 (row 0) -> done 1 cycle after the start edge; winner=01, win_line=0, game_over=1; a second scan_start is ignored (busy stays 0).
- Anti-diagonal (cells 4, 8, 12, 16, 20) = 10, rest empty -> done 12 cycles after the start edge; winner=10, win_line=11.
- Full board, no line matching, no 00 cells -> winner=00, draw=1, game_over=1. Repeat with one cell = 11 -> bad_cell=1, draw=1.
- Change board_in to a row-0 win 3 cycles into a scan of an empty board -> result uses the snapshot: winner=00. Assert clr mid-scan -> busy=0 next cycle, no done pulse, all outputs 0.
- With BOARD_JUDGE_AUTO_SCAN_EN, toggle player_done during a scan -> after REPORT, a second scan starts automatically (busy=1 the cycle after IDLE). Assert rst asynchronously mid-scan -> all outputs 0 immediately.
